// File: rtl/vme_slave_responder_if.sv
// ----------------------------------------------------------------------------
// vme_slave_responder_if
//   Bundles the VME slave-side bus signals and the local register bus of
//   vme_slave_responder.
//   slave  modport : the responder (VME strobes/address in, dtack/berr/data out,
//                    local strobes out, local read data/ack in)
//   master modport : the other side -- crate master plus register bank
// ----------------------------------------------------------------------------
interface vme_slave_responder_if;
    // VME side
    logic [4:0]  ga;
    logic        as;
    logic        ds0;
    logic        ds1;
    logic        write_b;
    logic        lword;
    logic        iack;
    logic [5:0]  am;
    logic [23:1] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        oe_b;
    logic        dtack;
    logic        berr;
    // local register bus side
    logic [17:0] loc_addr;
    logic        loc_wr;
    logic        loc_rd;
    logic [15:0] loc_wdata;
    logic [15:0] loc_rdata;
    logic        loc_ack;
    logic        busy;

    modport slave (
        input  ga, as, ds0, ds1, write_b, lword, iack, am, addr, data_in,
        input  loc_rdata, loc_ack,
        output data_out, oe_b, dtack, berr,
        output loc_addr, loc_wr, loc_rd, loc_wdata, busy
    );

    modport master (
        output ga, as, ds0, ds1, write_b, lword, iack, am, addr, data_in,
        output loc_rdata, loc_ack,
        input  data_out, oe_b, dtack, berr,
        input  loc_addr, loc_wr, loc_rd, loc_wdata, busy
    );
endinterface

// File: rtl/vme_slave_responder.sv
// ----------------------------------------------------------------------------
// vme_slave_responder
//   A24/D16 VME slave front end. Synchronises the asynchronous VME strobes,
//   decodes geographic address + address modifier, turns a selected cycle into
//   a single loc_wr/loc_rd pulse on the local register bus and answers the
//   master with dtack (or berr on lword/timeout), driving read data with oe_b.
// Ports
//   clk  : system clock, rising edge
//   rstn : asynchronous reset, active low
//   bus  : vme_slave_responder_if.slave -- VME strobes, address, data,
//          dtack/berr/oe_b, local register bus and busy
// ----------------------------------------------------------------------------
module vme_slave_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter int         TIMEOUT     = 255,
    parameter logic [5:0] AM_DATA     = 6'h39,
    parameter logic [5:0] AM_SUPV     = 6'h3D
) (
    input logic                  clk,
    input logic                  rstn,
    vme_slave_responder_if.slave bus
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, DECODE, ACCESS, ACK, ERR, REL, UNSEL
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] as_sync, ds0_sync, ds1_sync, wrb_sync;
    logic as_s, ds0_s, ds1_s, wrb_s;

    // Cycle attributes captured when leaving IDLE
    logic [23:1] addr_q;
    logic [5:0]  am_q;
    logic        rd_q;
    logic        lword_q;
    logic        iack_q;
    logic [15:0] din_q;

    logic [7:0]  tmo_cnt;
    logic        strobe, sel, start_access;

    logic        dtack_r, berr_r, oe_b_r, busy_r, loc_wr_r, loc_rd_r;
    logic [17:0] loc_addr_r;
    logic [15:0] loc_wdata_r, data_out_r;

    // Synchroniser chains; idle level of every strobe is high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            as_sync  <= '1;
            ds0_sync <= '1;
            ds1_sync <= '1;
            wrb_sync <= '1;
        end else begin
            as_sync  <= {as_sync[SYNC_STAGES-2:0],  bus.as};
            ds0_sync <= {ds0_sync[SYNC_STAGES-2:0], bus.ds0};
            ds1_sync <= {ds1_sync[SYNC_STAGES-2:0], bus.ds1};
            wrb_sync <= {wrb_sync[SYNC_STAGES-2:0], bus.write_b};
        end
    end

    assign as_s   = as_sync[SYNC_STAGES-1];
    assign ds0_s  = ds0_sync[SYNC_STAGES-1];
    assign ds1_s  = ds1_sync[SYNC_STAGES-1];
    assign wrb_s  = wrb_sync[SYNC_STAGES-1];
    assign strobe = !as_s && !ds0_s && !ds1_s;

    // Address/data are stable on the bus once the strobes are seen low
    always_ff @(posedge clk) begin
        if (state == IDLE && strobe) begin
            addr_q  <= bus.addr;
            am_q    <= bus.am;
            rd_q    <= wrb_s;
            lword_q <= bus.lword;
            iack_q  <= bus.iack;
            din_q   <= bus.data_in;
        end
    end

    assign sel = (addr_q[23:19] == bus.ga) &&
                 ((am_q == AM_DATA) || (am_q == AM_SUPV)) && iack_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (strobe) state_nxt = DECODE;
            DECODE:   if (!sel)          state_nxt = UNSEL;
                      else if (!lword_q) state_nxt = ERR;
                      else               state_nxt = ACCESS;
            // loc_ack has priority over both abort and timeout
            ACCESS:   if (bus.loc_ack)              state_nxt = ACK;
                      else if (as_s)                state_nxt = IDLE;
                      else if (tmo_cnt == TMO_LAST) state_nxt = ERR;
            ACK, ERR: if (ds0_s && ds1_s) state_nxt = REL;
            REL:      state_nxt = IDLE;
            UNSEL:    if (as_s) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign start_access = (state == DECODE) && (state_nxt == ACCESS);

    // Bus outputs are registered from the next state so they are glitch-free
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            dtack_r     <= 1'b1;
            berr_r      <= 1'b1;
            oe_b_r      <= 1'b1;
            busy_r      <= 1'b0;
            loc_wr_r    <= 1'b0;
            loc_rd_r    <= 1'b0;
            loc_addr_r  <= '0;
            loc_wdata_r <= '0;
            data_out_r  <= '0;
        end else begin
            state    <= state_nxt;
            loc_wr_r <= start_access && !rd_q;
            loc_rd_r <= start_access &&  rd_q;
            if (start_access) begin
                loc_addr_r  <= addr_q[18:1];
                loc_wdata_r <= din_q;
                tmo_cnt     <= '0;
            end else if (state == ACCESS) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
            if (state == ACCESS && bus.loc_ack && rd_q)
                data_out_r <= bus.loc_rdata;
            dtack_r <= (state_nxt != ACK);
            berr_r  <= (state_nxt != ERR);
            oe_b_r  <= !((state_nxt == ACK) && rd_q);
            busy_r  <= (state_nxt != IDLE);
        end
    end

    assign bus.dtack     = dtack_r;
    assign bus.berr      = berr_r;
    assign bus.oe_b      = oe_b_r;
    assign bus.busy      = busy_r;
    assign bus.loc_wr    = loc_wr_r;
    assign bus.loc_rd    = loc_rd_r;
    assign bus.loc_addr  = loc_addr_r;
    assign bus.loc_wdata = loc_wdata_r;
    assign bus.data_out  = data_out_r;

endmodule

// File: tb/tb_vme_slave_responder.sv
module tb_vme_slave_responder;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    vme_slave_responder_if bus ();

    vme_slave_responder #(
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ga;
        logic [23:0] baddr;   // VME byte address; bus.addr gets [23:1]
        logic [5:0]  am;
        logic        wr;
        logic        lword;
        logic        iack;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          ack_dly; // cycles after the loc strobe, -1 = never
        int          exp_wr;
        int          exp_rd;
        logic        exp_dt;  // dtack expected to go low
        logic        exp_be;  // berr expected to go low
        logic [17:0] exp_la;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] ga, input logic [23:0] ba, input logic [5:0] am,
                                input logic wr, input logic lw, input logic ik,
                                input logic [15:0] wd, input logic [15:0] rd, input int dly,
                                input int ew, input int er, input logic edt, input logic ebe,
                                input logic [17:0] ela);
        vec_t v;
        v.ga = ga; v.baddr = ba; v.am = am; v.wr = wr; v.lword = lw; v.iack = ik;
        v.wdata = wd; v.rdata = rd; v.ack_dly = dly;
        v.exp_wr = ew; v.exp_rd = er; v.exp_dt = edt; v.exp_be = ebe; v.exp_la = ela;
        return v;
    endfunction

    task automatic bus_idle();
        bus.ga = 5'd5; bus.as = 1'b1; bus.ds0 = 1'b1; bus.ds1 = 1'b1;
        bus.write_b = 1'b1; bus.lword = 1'b1; bus.iack = 1'b1; bus.am = 6'h00;
        bus.addr = '0; bus.data_in = '0; bus.loc_rdata = '0; bus.loc_ack = 1'b0;
    endtask

    task automatic start_cycle(input vec_t v);
        logic [23:0] ba;
        ba = v.baddr;
        bus.ga = v.ga; bus.addr = ba[23:1]; bus.am = v.am; bus.write_b = !v.wr;
        bus.lword = v.lword; bus.iack = v.iack; bus.data_in = v.wdata; bus.loc_rdata = v.rdata;
        bus.as = 1'b0; bus.ds0 = 1'b0; bus.ds1 = 1'b0;
    endtask

    task automatic release_strobes();
        bus.as = 1'b1; bus.ds0 = 1'b1; bus.ds1 = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int wr_n = 0, rd_n = 0, rd_cyc = 0, be_cyc = 0, ack_at = -1;
        logic saw_dt = 0, saw_be = 0, saw_busy = 0, win_bad = 0, released = 0, done = 0;
        logic [17:0] cap_la = '0;
        logic [15:0] cap_wd = '0, cap_do = '0;
        @(negedge clk);
        start_cycle(v);
        for (int cyc = 0; cyc < TIMEOUT + 60 && !done; cyc++) begin
            @(negedge clk);
            bus.loc_ack = 1'b0;
            if (bus.busy) saw_busy = 1;
            if (bus.loc_wr) begin
                wr_n++; cap_la = bus.loc_addr; cap_wd = bus.loc_wdata;
                if (v.ack_dly >= 0) ack_at = cyc + v.ack_dly;
            end
            if (bus.loc_rd) begin
                rd_n++; rd_cyc = cyc; cap_la = bus.loc_addr;
                if (v.ack_dly >= 0) ack_at = cyc + v.ack_dly;
            end
            if (cyc == ack_at) bus.loc_ack = 1'b1;
            if (!bus.dtack) begin
                saw_dt = 1; cap_do = bus.data_out;
                if (v.wr) win_bad |= (bus.oe_b !== 1'b1);
                else      win_bad |= (bus.oe_b !== 1'b0) || (bus.data_out !== v.rdata);
            end else if (bus.oe_b !== 1'b1) begin
                win_bad = 1;
            end
            if (!bus.berr && !saw_be) begin saw_be = 1; be_cyc = cyc; end
            if (!released && (saw_dt || saw_be || (cyc >= 12 && wr_n == 0 && rd_n == 0))) begin
                release_strobes();
                released = 1;
            end else if (released && bus.busy === 1'b0) begin
                done = 1;
            end
        end
        bus.loc_ack = 1'b0;
        check($sformatf("v%0d returned to idle in bound", idx), done, 1);
        check($sformatf("v%0d loc_wr count", idx), wr_n, v.exp_wr);
        check($sformatf("v%0d loc_rd count", idx), rd_n, v.exp_rd);
        check($sformatf("v%0d dtack asserted", idx), saw_dt, v.exp_dt);
        check($sformatf("v%0d berr asserted", idx), saw_be, v.exp_be);
        check($sformatf("v%0d busy seen", idx), saw_busy, 1);
        check($sformatf("v%0d oe_b/data window", idx), win_bad, 0);
        if (v.exp_wr + v.exp_rd > 0)
            check($sformatf("v%0d loc_addr", idx), cap_la, v.exp_la);
        if (v.exp_wr > 0)
            check($sformatf("v%0d loc_wdata", idx), cap_wd, v.wdata);
        if (v.exp_rd > 0 && v.exp_dt)
            check($sformatf("v%0d data_out", idx), cap_do, v.rdata);
        if (v.exp_rd > 0 && v.exp_be)
            check($sformatf("v%0d berr delay after loc_rd", idx), be_cyc - rd_cyc, TIMEOUT);
        check($sformatf("v%0d idle outputs {dtack,berr,oe_b,busy}", idx),
              {bus.dtack, bus.berr, bus.oe_b, bus.busy}, 4'b1110);
        bus_idle();
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs[10];

    initial begin
        logic saw_dt, saw_bad, got;
        vec_t va;
        int wait_n;

        vecs[0] = mk(5'd5,  24'h280010, 6'h39, 1, 1, 1, 16'hBEEF, 16'h0000,  3, 1, 0, 1, 0, 18'h00008);
        vecs[1] = mk(5'd5,  24'h280010, 6'h39, 0, 1, 1, 16'h0000, 16'h1234,  3, 0, 1, 1, 0, 18'h00008);
        vecs[2] = mk(5'd5,  24'h300010, 6'h39, 1, 1, 1, 16'h1111, 16'h0000,  1, 0, 0, 0, 0, 18'h00000);
        vecs[3] = mk(5'd5,  24'h280010, 6'h09, 0, 1, 1, 16'h0000, 16'h2222,  1, 0, 0, 0, 0, 18'h00000);
        vecs[4] = mk(5'd5,  24'h281FFE, 6'h3D, 0, 1, 1, 16'h0000, 16'hA5A5,  0, 0, 1, 1, 0, 18'h00FFF);
        vecs[5] = mk(5'd5,  24'h280020, 6'h39, 0, 1, 1, 16'h0000, 16'h3333, -1, 0, 1, 0, 1, 18'h00010);
        vecs[6] = mk(5'd5,  24'h280010, 6'h39, 1, 0, 1, 16'hCAFE, 16'h0000,  1, 0, 0, 0, 1, 18'h00000);
        vecs[7] = mk(5'd5,  24'h280010, 6'h39, 1, 1, 0, 16'hDEAD, 16'h0000,  1, 0, 0, 0, 0, 18'h00000);
        vecs[8] = mk(5'd31, 24'hFFFFFE, 6'h3D, 1, 1, 1, 16'h0001, 16'h0000,  1, 1, 0, 1, 0, 18'h3FFFF);
        vecs[9] = mk(5'd0,  24'h000002, 6'h39, 0, 1, 1, 16'h0000, 16'hFFFF,  5, 0, 1, 1, 0, 18'h00001);

        bus_idle();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset dtack",     bus.dtack,     1);
        check("reset berr",      bus.berr,      1);
        check("reset oe_b",      bus.oe_b,      1);
        check("reset data_out",  bus.data_out,  0);
        check("reset loc_wr",    bus.loc_wr,    0);
        check("reset loc_rd",    bus.loc_rd,    0);
        check("reset loc_addr",  bus.loc_addr,  0);
        check("reset loc_wdata", bus.loc_wdata, 0);
        check("reset busy",      bus.busy,      0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Master abort: as released while waiting for loc_ack, then a late ack
        va = mk(5'd5, 24'h280010, 6'h39, 1, 1, 1, 16'h5555, 16'h0000, -1, 1, 0, 0, 0, 18'h8);
        @(negedge clk);
        start_cycle(va);
        got = 0; saw_dt = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.loc_wr) got = 1;
            if (!bus.dtack) saw_dt = 1;
        end
        check("abort loc_wr issued", got, 1);
        repeat (2) @(negedge clk);
        release_strobes();
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (!bus.dtack) saw_dt = 1;
            if (bus.busy === 1'b0) got = 1;
        end
        check("abort back to idle", got, 1);
        bus.loc_ack = 1'b1;
        @(negedge clk);
        bus.loc_ack = 1'b0;
        saw_bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (!bus.dtack) saw_dt = 1;
            if (bus.busy || bus.loc_wr || bus.loc_rd || !bus.berr) saw_bad = 1;
        end
        check("abort no dtack", saw_dt, 0);
        check("abort late ack ignored", saw_bad, 0);
        bus_idle();
        repeat (2) @(negedge clk);

        // Reset pulsed while dtack is asserted
        va = mk(5'd5, 24'h280010, 6'h39, 0, 1, 1, 16'h0000, 16'h5A5A, 1, 0, 1, 1, 0, 18'h8);
        @(negedge clk);
        start_cycle(va);
        got = 0; wait_n = -1;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            bus.loc_ack = 1'b0;
            if (bus.loc_rd) wait_n = c + 1;
            if (c == wait_n) bus.loc_ack = 1'b1;
            if (!bus.dtack) got = 1;
        end
        bus.loc_ack = 1'b0;
        check("rst-in-ack dtack reached", got, 1);
        #2 rstn = 1'b0;
        #1;
        check("rst-in-ack dtack",    bus.dtack,    1);
        check("rst-in-ack busy",     bus.busy,     0);
        check("rst-in-ack oe_b",     bus.oe_b,     1);
        check("rst-in-ack data_out", bus.data_out, 0);
        release_strobes();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        saw_bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.loc_wr || bus.loc_rd || bus.busy || !bus.dtack || !bus.berr) saw_bad = 1;
        end
        check("no strobe after reset exit", saw_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
